// File: rtl/sol32_exec_pkg.sv
// Shared types for the sol32 execute stage: opcode and condition enums, flag
// layout and the bit-counting helpers used by the one-operand ALU.
package sol32_exec_pkg;

    typedef enum logic [3:0] {
        ALU2_ADD  = 4'h0, ALU2_SUB  = 4'h1, ALU2_RSUB = 4'h2, ALU2_AND  = 4'h3,
        ALU2_OR   = 4'h4, ALU2_XOR  = 4'h5, ALU2_ANDN = 4'h6, ALU2_SLL  = 4'h7,
        ALU2_SRL  = 4'h8, ALU2_SRA  = 4'h9, ALU2_ROL  = 4'hA, ALU2_ROR  = 4'hB,
        ALU2_MIN  = 4'hC, ALU2_MAX  = 4'hD, ALU2_MINU = 4'hE, ALU2_MAXU = 4'hF
    } alu2_op_e;

    typedef enum logic [3:0] {
        ALU1_MOV    = 4'h0, ALU1_NOT    = 4'h1, ALU1_NEG    = 4'h2, ALU1_INC    = 4'h3,
        ALU1_DEC    = 4'h4, ALU1_ABS    = 4'h5, ALU1_CLZ    = 4'h6, ALU1_CTZ    = 4'h7,
        ALU1_POPCNT = 4'h8, ALU1_BSWAP  = 4'h9, ALU1_BITREV = 4'hA, ALU1_SEXT8  = 4'hB,
        ALU1_SEXT16 = 4'hC, ALU1_ZEXT8  = 4'hD, ALU1_ZEXT16 = 4'hE, ALU1_MOVF   = 4'hF
    } alu1_op_e;

    typedef enum logic [3:0] {
        COND_AL  = 4'h0, COND_EQ  = 4'h1, COND_NE  = 4'h2, COND_LT  = 4'h3,
        COND_GE  = 4'h4, COND_LTU = 4'h5, COND_GEU = 4'h6, COND_GT  = 4'h7,
        COND_LE  = 4'h8, COND_GTU = 4'h9, COND_LEU = 4'hA, COND_ZS  = 4'hB,
        COND_NS  = 4'hC, COND_CS  = 4'hD, COND_VS  = 4'hE, COND_NV  = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

    // Zero input yields 32 for both leading and trailing counts.
    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++)
            if (v[i]) n = 6'(31 - i);
        return n;
    endfunction

    function automatic logic [5:0] ctz32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 31; i >= 0; i--)
            if (v[i]) n = 6'(i);
        return n;
    endfunction

    function automatic logic [5:0] popcnt32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++)
            n = n + {5'b0, v[i]};
        return n;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            r[i] = v[31 - i];
        return r;
    endfunction

endpackage

// File: rtl/sol32_exec_unit_cond.sv
// Branch condition evaluator: relational codes compare the raw operands,
// flag codes test the flags produced by the current operation.
module sol32_cond_eval
    import sol32_exec_pkg::*;
(
    input  logic [3:0]  cond,
    input  flags_t      flags,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_AL:  cond_true = 1'b1;
            COND_EQ:  cond_true = (a == b);
            COND_NE:  cond_true = (a != b);
            COND_LT:  cond_true = ($signed(a) <  $signed(b));
            COND_GE:  cond_true = ($signed(a) >= $signed(b));
            COND_LTU: cond_true = (a <  b);
            COND_GEU: cond_true = (a >= b);
            COND_GT:  cond_true = ($signed(a) >  $signed(b));
            COND_LE:  cond_true = ($signed(a) <= $signed(b));
            COND_GTU: cond_true = (a >  b);
            COND_LEU: cond_true = (a <= b);
            COND_ZS:  cond_true = flags[FLAG_Z];
            COND_NS:  cond_true = flags[FLAG_N];
            COND_CS:  cond_true = flags[FLAG_C];
            COND_VS:  cond_true = flags[FLAG_V];
            COND_NV:  cond_true = 1'b0;
            default:  cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/sol32_exec_unit.sv
// sol32 execute stage: two-operand and one-operand ALUs sharing one 33-bit
// adder, a condition evaluator, and a single output register stage.
module sol32_exec_unit
    import sol32_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ValidIn,
    input  logic             UnitSel,
    input  logic [3:0]       Op,
    input  logic [3:0]       Cond,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags,
    output logic             CondTrue,
    output logic             ValidOut
);

    logic [WIDTH-1:0] add_x, add_y;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             add_v;
    logic [4:0]       shamt;
    logic [WIDTH:0]   sll_t, srl_t, sra_t;
    logic [WIDTH-1:0] rol_r, ror_r;
    logic [WIDTH-1:0] res;
    logic             c_flag, v_flag;
    flags_t           flags_nx;
    logic             cond_nx;
    alu2_op_e         op2;
    alu1_op_e         op1;

    assign op2 = alu2_op_e'(Op);
    assign op1 = alu1_op_e'(Op);

    // Every add/subtract-style op is folded onto x + y + cin.
    always_comb begin
        add_x   = OperandA;
        add_y   = '0;
        add_cin = 1'b0;
        if (!UnitSel) begin
            case (op2)
                ALU2_ADD:  add_y = OperandB;
                ALU2_SUB:  begin add_y = ~OperandB; add_cin = 1'b1; end
                ALU2_RSUB: begin add_x = OperandB; add_y = ~OperandA; add_cin = 1'b1; end
                default:   ;
            endcase
        end else begin
            case (op1)
                ALU1_NEG: begin add_x = '0; add_y = ~OperandA; add_cin = 1'b1; end
                ALU1_INC: add_cin = 1'b1;
                ALU1_DEC: begin add_y = {{(WIDTH-1){1'b1}}, 1'b0}; add_cin = 1'b1; end
                ALU1_ABS: begin
                    if (OperandA[WIDTH-1]) begin
                        add_x   = '0;
                        add_y   = ~OperandA;
                        add_cin = 1'b1;
                    end
                end
                default:  ;
            endcase
        end
    end

    assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

    // The extra bit on each shift captures the last bit pushed out.
    assign shamt = OperandB[4:0];
    assign sll_t = {1'b0, OperandA} << shamt;
    assign srl_t = {OperandA, 1'b0} >> shamt;
    assign sra_t = $signed({OperandA, 1'b0}) >>> shamt;
    assign rol_r = (OperandA << shamt) | (OperandA >> (6'd32 - {1'b0, shamt}));
    assign ror_r = (OperandA >> shamt) | (OperandA << (6'd32 - {1'b0, shamt}));

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        if (!UnitSel) begin
            case (op2)
                ALU2_ADD, ALU2_SUB, ALU2_RSUB: begin
                    res = sum[WIDTH-1:0]; c_flag = sum[WIDTH]; v_flag = add_v;
                end
                ALU2_AND:  res = OperandA & OperandB;
                ALU2_OR:   res = OperandA | OperandB;
                ALU2_XOR:  res = OperandA ^ OperandB;
                ALU2_ANDN: res = OperandA & ~OperandB;
                ALU2_SLL:  begin res = sll_t[WIDTH-1:0]; c_flag = sll_t[WIDTH]; end
                ALU2_SRL:  begin res = srl_t[WIDTH:1]; c_flag = srl_t[0]; end
                ALU2_SRA:  begin res = sra_t[WIDTH:1]; c_flag = sra_t[0]; end
                ALU2_ROL:  begin res = rol_r; c_flag = (shamt != 5'd0) && rol_r[0]; end
                ALU2_ROR:  begin res = ror_r; c_flag = (shamt != 5'd0) && ror_r[WIDTH-1]; end
                ALU2_MIN:  res = ($signed(OperandA) < $signed(OperandB)) ? OperandA : OperandB;
                ALU2_MAX:  res = ($signed(OperandA) > $signed(OperandB)) ? OperandA : OperandB;
                ALU2_MINU: res = (OperandA < OperandB) ? OperandA : OperandB;
                ALU2_MAXU: res = (OperandA > OperandB) ? OperandA : OperandB;
                default:   res = '0;
            endcase
        end else begin
            case (op1)
                ALU1_MOV, ALU1_MOVF: res = OperandA;
                ALU1_NOT:    res = ~OperandA;
                ALU1_NEG, ALU1_INC, ALU1_DEC: begin
                    res = sum[WIDTH-1:0]; c_flag = sum[WIDTH]; v_flag = add_v;
                end
                ALU1_ABS:    begin res = sum[WIDTH-1:0]; v_flag = add_v; end
                ALU1_CLZ:    res = WIDTH'(clz32(OperandA));
                ALU1_CTZ:    res = WIDTH'(ctz32(OperandA));
                ALU1_POPCNT: res = WIDTH'(popcnt32(OperandA));
                ALU1_BSWAP:  res = {OperandA[7:0], OperandA[15:8], OperandA[23:16], OperandA[31:24]};
                ALU1_BITREV: res = bitrev32(OperandA);
                ALU1_SEXT8:  res = {{24{OperandA[7]}}, OperandA[7:0]};
                ALU1_SEXT16: res = {{16{OperandA[15]}}, OperandA[15:0]};
                ALU1_ZEXT8:  res = {24'b0, OperandA[7:0]};
                ALU1_ZEXT16: res = {16'b0, OperandA[15:0]};
                default:     res = '0;
            endcase
        end
    end

    always_comb begin
        flags_nx         = '0;
        flags_nx[FLAG_N] = res[WIDTH-1];
        flags_nx[FLAG_Z] = (res == '0);
        flags_nx[FLAG_C] = c_flag;
        flags_nx[FLAG_V] = v_flag;
    end

    sol32_cond_eval u_cond (
        .cond      (Cond),
        .flags     (flags_nx),
        .a         (OperandA),
        .b         (OperandB),
        .cond_true (cond_nx)
    );

    // Outputs hold while no operation is presented; only ValidOut drops.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            Result   <= '0;
            Flags    <= '0;
            CondTrue <= 1'b0;
            ValidOut <= 1'b0;
        end else begin
            ValidOut <= ValidIn;
            if (ValidIn) begin
                Result   <= res;
                Flags    <= flags_nx;
                CondTrue <= cond_nx;
            end
        end
    end

endmodule

// File: tb/tb_sol32_exec_unit.sv
// Directed scoreboard bench for sol32_exec_unit: each step queues its expected
// registered outputs and checks them one cycle later.
module tb_sol32_exec_unit;
    import sol32_exec_pkg::*;

    logic        clock;
    logic        reset;
    logic        valid_in;
    logic        unit_sel;
    logic [3:0]  op;
    logic [3:0]  cond;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        cond_true;
    logic        valid_out;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        cond_true;
        logic        valid;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    sol32_exec_unit #(.WIDTH(32)) dut (
        .Clock    (clock),
        .Reset    (reset),
        .ValidIn  (valid_in),
        .UnitSel  (unit_sel),
        .Op       (op),
        .Cond     (cond),
        .OperandA (operand_a),
        .OperandB (operand_b),
        .Result   (result),
        .Flags    (flags),
        .CondTrue (cond_true),
        .ValidOut (valid_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard: got empty queue want one entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (result === e.result) else begin
            errors++;
            $error("[TB] FAIL %s result: got %h want %h", e.tag, result, e.result);
        end
        checks++;
        assert (flags === e.flags) else begin
            errors++;
            $error("[TB] FAIL %s flags: got %b want %b", e.tag, flags, e.flags);
        end
        checks++;
        assert (cond_true === e.cond_true) else begin
            errors++;
            $error("[TB] FAIL %s cond_true: got %b want %b", e.tag, cond_true, e.cond_true);
        end
        checks++;
        assert (valid_out === e.valid) else begin
            errors++;
            $error("[TB] FAIL %s valid_out: got %b want %b", e.tag, valid_out, e.valid);
        end
    endtask

    // Idle steps expect the previously captured values with valid_out low.
    task automatic apply_stimulus(input string tag, input logic vld, input logic unit,
                                  input logic [3:0] o, input logic [3:0] c,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] er, input logic [3:0] ef, input logic ect);
        valid_in  = vld;
        unit_sel  = unit;
        op        = o;
        cond      = c;
        operand_a = a;
        operand_b = b;
        if (vld) begin
            last = '{er, ef, ect, 1'b1, tag};
            sb.push_back(last);
        end else begin
            sb.push_back('{last.result, last.flags, last.cond_true, 1'b0, tag});
        end
        @(posedge clock);
        #1;
        check_output();
    endtask

    task automatic apply_reset(input string tag);
        reset     = 1'b0;
        valid_in  = 1'b1;
        unit_sel  = 1'b0;
        op        = ALU2_ADD;
        cond      = COND_AL;
        operand_a = 32'd1;
        operand_b = 32'd2;
        last = '{32'h0, 4'h0, 1'b0, 1'b0, tag};
        sb.push_back(last);
        @(posedge clock);
        #1;
        check_output();
    endtask

    initial begin
        reset = 1'b0;
        valid_in = 1'b0; unit_sel = 1'b0; op = '0; cond = '0; operand_a = '0; operand_b = '0;

        apply_reset("reset0");
        apply_reset("reset1");
        reset = 1'b1;

        apply_stimulus("add_1_2",    1, 0, ALU2_ADD,  COND_AL,  32'd1,        32'd2,        32'd3,        4'b0000, 1);
        apply_stimulus("add_carry",  1, 0, ALU2_ADD,  COND_EQ,  32'hFFFFFFFF, 32'd1,        32'h0,        4'b0110, 0);
        apply_stimulus("add_ovf",    1, 0, ALU2_ADD,  COND_GT,  32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b1001, 1);
        apply_stimulus("sub_5_7",    1, 0, ALU2_SUB,  COND_LTU, 32'd5,        32'd7,        32'hFFFFFFFE, 4'b1000, 1);
        apply_stimulus("sub_7_5",    1, 0, ALU2_SUB,  COND_GE,  32'd7,        32'd5,        32'd2,        4'b0010, 1);
        apply_stimulus("sub_ovf",    1, 0, ALU2_SUB,  COND_LT,  32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0011, 1);
        apply_stimulus("rsub",       1, 0, ALU2_RSUB, COND_NE,  32'd7,        32'd5,        32'hFFFFFFFE, 4'b1000, 1);
        apply_stimulus("sra",        1, 0, ALU2_SRA,  COND_NS,  32'h80000010, 32'd4,        32'hF8000001, 4'b1000, 1);
        apply_stimulus("sra_cs",     1, 0, ALU2_SRA,  COND_CS,  32'h80000010, 32'd4,        32'hF8000001, 4'b1000, 0);
        apply_stimulus("sll",        1, 0, ALU2_SLL,  COND_CS,  32'hC0000000, 32'd1,        32'h80000000, 4'b1010, 1);
        apply_stimulus("ror",        1, 0, ALU2_ROR,  COND_VS,  32'h00000001, 32'd1,        32'h80000000, 4'b1010, 0);
        apply_stimulus("rol",        1, 0, ALU2_ROL,  COND_ZS,  32'h80000001, 32'd4,        32'h00000018, 4'b0000, 0);
        apply_stimulus("srl",        1, 0, ALU2_SRL,  COND_AL,  32'h0000000F, 32'd2,        32'd3,        4'b0010, 1);
        apply_stimulus("sll_zero",   1, 0, ALU2_SLL,  COND_AL,  32'h80000001, 32'd32,       32'h80000001, 4'b1000, 1);
        apply_stimulus("min_s",      1, 0, ALU2_MIN,  COND_LE,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 4'b1000, 1);
        apply_stimulus("minu",       1, 0, ALU2_MINU, COND_GTU, 32'hFFFFFFFF, 32'd1,        32'd1,        4'b0000, 1);
        apply_stimulus("andn",       1, 0, ALU2_ANDN, COND_LEU, 32'hF0F0FFFF, 32'h0F0FFF00, 32'hF0F000FF, 4'b1000, 0);
        apply_stimulus("clz_0",      1, 1, ALU1_CLZ,  COND_EQ,  32'h0,        32'h0,        32'd32,       4'b0000, 1);
        apply_stimulus("clz_16",     1, 1, ALU1_CLZ,  COND_NV,  32'h00010000, 32'h0,        32'd15,       4'b0000, 0);
        apply_stimulus("ctz",        1, 1, ALU1_CTZ,  COND_AL,  32'h00000100, 32'h0,        32'd8,        4'b0000, 1);
        apply_stimulus("popcnt",     1, 1, ALU1_POPCNT, COND_AL, 32'hF0F0F0F0, 32'h0,       32'd16,       4'b0000, 1);
        apply_stimulus("bswap",      1, 1, ALU1_BSWAP, COND_GTU, 32'h11223344, 32'h0,       32'h44332211, 4'b0000, 1);
        apply_stimulus("bitrev",     1, 1, ALU1_BITREV, COND_NS, 32'h00000001, 32'h0,       32'h80000000, 4'b1000, 1);
        apply_stimulus("neg_min",    1, 1, ALU1_NEG,  COND_VS,  32'h80000000, 32'h0,        32'h80000000, 4'b1001, 1);
        apply_stimulus("neg_0",      1, 1, ALU1_NEG,  COND_CS,  32'h0,        32'h5,        32'h0,        4'b0110, 1);
        apply_stimulus("abs_min",    1, 1, ALU1_ABS,  COND_AL,  32'h80000000, 32'h0,        32'h80000000, 4'b1001, 1);
        apply_stimulus("abs_neg",    1, 1, ALU1_ABS,  COND_AL,  32'hFFFFFFFB, 32'h0,        32'd5,        4'b0000, 1);
        apply_stimulus("dec_0",      1, 1, ALU1_DEC,  COND_ZS,  32'h0,        32'h0,        32'hFFFFFFFF, 4'b1000, 0);
        apply_stimulus("dec_1",      1, 1, ALU1_DEC,  COND_ZS,  32'd1,        32'h0,        32'h0,        4'b0110, 1);
        apply_stimulus("inc_wrap",   1, 1, ALU1_INC,  COND_ZS,  32'hFFFFFFFF, 32'h0,        32'h0,        4'b0110, 1);
        apply_stimulus("sext8",      1, 1, ALU1_SEXT8, COND_NS, 32'h00000080, 32'h0,        32'hFFFFFF80, 4'b1000, 1);
        apply_stimulus("zext16",     1, 1, ALU1_ZEXT16, COND_LT, 32'hFFFF8001, 32'h0,       32'h00008001, 4'b0000, 1);
        apply_stimulus("maxu",       1, 0, ALU2_MAXU, COND_LTU, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 1);
        apply_stimulus("hold0",      0, 0, ALU2_ADD,  COND_NV,  32'd1,        32'd1,        32'h0,        4'h0,    0);
        apply_stimulus("hold1",      0, 1, ALU1_NOT,  COND_NV,  32'h0,        32'h0,        32'h0,        4'h0,    0);
        apply_stimulus("eq_1234",    1, 0, ALU2_ADD,  COND_EQ,  32'h1234,     32'h1234,     32'h2468,     4'b0000, 1);
        apply_stimulus("nv_1234",    1, 0, ALU2_ADD,  COND_NV,  32'h1234,     32'h1234,     32'h2468,     4'b0000, 0);
        apply_stimulus("al_any",     1, 0, ALU2_XOR,  COND_AL,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        4'b0100, 1);

        apply_reset("reset_late");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sol32_exec_unit.md
Name: sol32_exec_unit

Overview:
- Execute stage of the sol32 core. Combines three functions:
  - a two-operand ALU (ALU2 function),
  - a one-operand ALU (ALU1 function),
  - a condition comparator that uses the selected unit's flags and the raw operands.
- All outputs are registered, with one-cycle latency.
- The result feeds register-bank writeback; CondTrue gates conditional-jump writeback.

Parameters:
- WIDTH, 32, datapath width. Only 32 is required and verified.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- ValidIn  in  1  operation present this cycle.
- UnitSel  in  1  0 = ALU2 (A op B), 1 = ALU1 (op A).
- Op  in  4  operation code for the selected unit.
- Cond  in  4  comparator condition code.
- OperandA  in  32  source 1.
- OperandB  in  32  source 2 (ignored by ALU1 ops).
- Result  out  32  registered result.
- Flags  out  4  registered {N,Z,C,V}, bit 3 = N.
- CondTrue  out  1  registered comparator outcome.
- ValidOut  out  1  ValidIn delayed by one cycle.

Behaviour:
- Reset (Reset==0 at a clock edge): Result=0, Flags=0, CondTrue=0, ValidOut=0. Reset overrides ValidIn in the same cycle.
- Register update:
  - Each edge with Reset==1 and ValidIn==1: capture Result, Flags and CondTrue from the combinational logic; ValidOut<=1.
  - ValidIn==0: Result, Flags and CondTrue hold their values; ValidOut<=0.
- ALU2 ops (shift amount = B[4:0]; amount 0 leaves A unchanged with C=0):
  - 0 ADD, 1 SUB (A-B), 2 RSUB (B-A), 3 AND, 4 OR, 5 XOR, 6 ANDN (A&~B).
  - 7 SLL, 8 SRL, 9 SRA, A ROL, B ROR.
  - C MIN signed, D MAX signed, E MINU, F MAXU.
- ALU1 ops:
  - 0 MOV, 1 NOT, 2 NEG (0-A), 3 INC, 4 DEC, 5 ABS (ABS of 0x80000000 = 0x80000000, V=1).
  - 6 CLZ, 7 CTZ (both return 32 for A=0), 8 POPCNT.
  - 9 BSWAP, A BITREV, B SEXT8, C SEXT16, D ZEXT8, E ZEXT16, F MOV.
- Flags:
  - N = Result[31]; Z = (Result==0) for every op.
  - C:
    - ADD, INC: carry out of bit 31.
    - SUB, RSUB, NEG, DEC: no-borrow (1 when minuend >= subtrahend unsigned). NEG treats A as the subtrahend of 0 (C=1 only for A=0); DEC treats 1 as the subtrahend.
    - Shifts and rotates: last bit shifted or rotated out.
    - All other ops: 0.
  - V:
    - ADD, SUB, RSUB, NEG, INC, DEC, ABS: two's-complement overflow.
    - All other ops: 0.
- Comparator: uses the flags of the selected unit in the same cycle (not the registered flags).
  - 0 AL (always 1), 1 EQ, 2 NE.
  - 3 LT signed, 4 GE signed, 5 LTU, 6 GEU.
  - 7 GT signed, 8 LE signed, 9 GTU, A LEU.
  - B Z set, C N set, D C set, E V set, F NV (always 0).
  - Codes 1–A compare OperandA against OperandB directly and are independent of Op.
- All arithmetic is modulo 2^32. There is no trap or exception state.

Decomposition:
- Package sol32_exec_pkg:
  - enums alu2_op_e, alu1_op_e, cond_e (4-bit),
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0,
  - a 4-bit flags_t typedef.
- One sub-module: sol32_cond_eval (combinational; inputs Cond, flags, A, B; output 1 bit).
- The ALU datapaths are case blocks in the top module.
- A single 33-bit adder is shared across ADD, SUB, RSUB, NEG, INC, DEC and ABS.

Test Plan:
- Reset=0 for 2 cycles with ValidIn=1 -> Result=0, Flags=0, CondTrue=0, ValidOut=0. Release reset, then ADD 1+2 -> next cycle Result=3, Flags=0000, ValidOut=1.
- ALU2 ADD 0xFFFFFFFF+1 -> Result=0, Flags=0110 (Z,C). ADD 0x7FFFFFFF+1 -> Result=0x80000000, Flags=1001 (N,V).
- ALU2 SUB 5-7 with Cond=LTU -> Result=0xFFFFFFFE, Flags=1000, CondTrue=1. SUB 7-5 with Cond=GE -> Result=2, Flags=0010, CondTrue=1.
- ALU2 SRA 0x80000010 by B=4 -> Result=0xF8000001, C=0. SLL 0xC0000000 by 1 -> Result=0x80000000, C=1. ROR 0x1 by 1 -> 0x80000000, C=1.
- ALU1 CLZ 0 -> 32. CLZ 0x00010000 -> 15. POPCNT 0xF0F0F0F0 -> 16. BSWAP 0x11223344 -> 0x44332211. NEG 0x80000000 -> 0x80000000 with V=1, C=0. SEXT8 0x80 -> 0xFFFFFF80.
- Hold and conditions:
  - ValidIn=0 after MAXU(3, 0xFFFFFFFF)=0xFFFFFFFF -> outputs hold, ValidOut=0.
  - Cond=AL -> CondTrue=1 and Cond=NV -> CondTrue=0 for any operands.
  - Cond=EQ with A=B=0x1234 -> 1.
